uro_load_unit: RTL and testbench
================================

URO_LOAD_UNIT -- requirements
Module: uro_load_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning load data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width in bits.
REQ-003 SHALL have parameter UROM_DEPTH, default 1024, meaning number of ROM words.
REQ-004 SHALL have ports:
- i_CLK  input  1  single clock; all state on rising edge.
- i_RSTn  input  1  asynchronous, active-low reset.
- i_REQ  input  1  core load request.
- o_GNT  output  1  request accepted this cycle.
- i_ADDR  input  ADDR_WIDTH  byte address.
- i_FUNCT3  input  3  RV32I load type.
- o_RDATA  output  DATA_WIDTH  formatted load result.
- o_RVALID  output  1  result valid.
- i_RREADY  input  1  core accepts result.
- o_ERR  output  1  result is an error; qualified by o_RVALID.
- o_UROM_CE  output  1  ROM read enable.
- o_UROM_ADDR  output  ADDR_WIDTH  ROM word index.
- i_UROM_RDATA  input  DATA_WIDTH  ROM read data.
- i_UROM_VALID  input  1  ROM data valid; arrives one cycle after o_UROM_CE.

Function
REQ-005 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-006 SHALL drive o_GNT = i_REQ in IDLE only; a request is accepted when i_REQ and o_GNT are both high.
REQ-007 SHALL, on an accepted legal request, assert o_UROM_CE for exactly that one cycle and go to WAIT.
- o_UROM_ADDR = i_ADDR >> 2, zero-extended to ADDR_WIDTH.
- i_ADDR[1:0] and i_FUNCT3 latched.
REQ-008 SHALL keep o_UROM_CE low in all other cycles; o_UROM_ADDR is don't-care when o_UROM_CE is low.
REQ-009 SHALL, in WAIT, on i_UROM_VALID high, register the formatted result into o_RDATA and go to RESP; with i_UROM_VALID low, stay in WAIT.
REQ-010 SHALL format the result by load type:
- LB (000) and LBU (100): select byte offset[1:0].
- LH (001) and LHU (101): select halfword offset[1].
- LW (010): select the whole word.
- LB/LH sign-extend; LBU/LHU zero-extend.
REQ-011 SHALL treat i_FUNCT3 values 011, 110 and 111 as illegal:
- no ROM access is made;
- next state is RESP with o_RDATA=0 and o_ERR=1.
REQ-012 SHALL, in RESP, hold o_RVALID=1 and keep o_RDATA/o_ERR stable until i_RREADY is high, then go to IDLE on the next edge.
REQ-013 SHALL NOT accept a new request in the RESP-exit cycle; minimum initiation interval is 3 cycles.
REQ-014 SHALL keep o_RVALID and o_ERR low outside RESP.
REQ-015 SHALL ignore i_UROM_VALID outside WAIT.

Reset
REQ-016 SHALL, on i_RSTn low, asynchronously enter IDLE with these outputs:
- o_RDATA=0, o_RVALID=0, o_ERR=0, o_UROM_CE=0, o_UROM_ADDR=0;
- latched offset and funct3 cleared to 0.
REQ-017 SHALL, if reset is asserted in WAIT or RESP:
- abandon the transaction;
- discard a late ROM response;
- produce no o_RVALID after reset release.

Configuration
REQ-018 SHALL use the macro UROM_LOAD_MISALIGN_EN.
REQ-019 SHALL, with UROM_LOAD_MISALIGN_EN defined, treat misaligned requests like illegal ones (REQ-011):
- LH/LHU with addr[0]=1;
- LW with addr[1:0]!=0;
- result: no ROM access, o_RDATA=0, o_ERR=1.
REQ-020 SHALL, without UROM_LOAD_MISALIGN_EN, perform the access regardless of alignment:
- LH/LHU ignore addr[0];
- LW ignores addr[1:0];
- o_ERR is set only for illegal funct3.

Verification (ROM word0=0x80017F80, word1=0x12345678)
REQ-021 LB addr 0x0, i_RREADY=1 -> one o_UROM_CE with addr 0; o_RVALID at cycle 3 with o_RDATA=0xFFFFFF80, o_ERR=0.
REQ-022 LBU addr 0x1, then LHU addr 0x2 -> 0x0000007F, then 0x00008001 (LH at addr 0x2 -> 0xFFFF8001).
REQ-023 LW addr 0x4 with i_RREADY low for 5 cycles -> o_RVALID and o_RDATA=0x12345678 held stable for 5 cycles; o_GNT low throughout; then IDLE.
REQ-024 funct3=011 at addr 0x0 -> no o_UROM_CE; o_RVALID with o_RDATA=0 and o_ERR=1.
REQ-025 LW addr 0x6 -> with the macro: no ROM access, o_ERR=1, o_RDATA=0; without it: o_RDATA=0x12345678, o_ERR=0.
REQ-026 i_RSTn pulsed low in WAIT -> all outputs 0 immediately; the following i_UROM_VALID is ignored; the next LW addr 0x0 returns 0x80017F80.

Source files
------------

// File: rtl/uro_load_unit.sv
// Load unit that reads RV32I loads from a word-organised micro-ROM and formats the result.
// Optional build macro UROM_LOAD_MISALIGN_EN turns misaligned LH/LHU/LW into error responses.
module uro_load_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned UROM_DEPTH = 1024
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_REQ,
  output logic                  o_GNT,
  input  logic [ADDR_WIDTH-1:0] i_ADDR,
  input  logic [2:0]            i_FUNCT3,
  output logic [DATA_WIDTH-1:0] o_RDATA,
  output logic                  o_RVALID,
  input  logic                  i_RREADY,
  output logic                  o_ERR,
  output logic                  o_UROM_CE,
  output logic [ADDR_WIDTH-1:0] o_UROM_ADDR,
  input  logic [DATA_WIDTH-1:0] i_UROM_RDATA,
  input  logic                  i_UROM_VALID
);

  if (UROM_DEPTH == 0 || $clog2(UROM_DEPTH) > ADDR_WIDTH - 2) begin : g_depth_check
    $error("UROM_DEPTH does not fit the word index range of ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic                  misaligned;
  logic                  illegal;

`ifdef UROM_LOAD_MISALIGN_EN
  assign misaligned = ((i_FUNCT3[1:0] == 2'b01) && i_ADDR[0]) ||
                      ((i_FUNCT3 == 3'b010) && (i_ADDR[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign illegal = (i_FUNCT3 == 3'b011) || (i_FUNCT3[2:1] == 2'b11) || misaligned;

  // Handshake outputs are gated by reset so they drop the instant reset asserts.
  assign o_GNT       = i_RSTn && i_REQ && (state_q == S_IDLE);
  assign o_UROM_CE   = o_GNT && !illegal;
  assign o_UROM_ADDR = o_UROM_CE ? (i_ADDR >> 2) : '0;
  assign o_RVALID    = (state_q == S_RESP);
  assign o_ERR       = o_RVALID && err_q;
  assign o_RDATA     = rdata_q;

  function automatic logic [DATA_WIDTH-1:0] fmt_load(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            off,
    input logic [2:0]            fn
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (fn)
      3'b000:  fmt_load = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b100:  fmt_load = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b001:  fmt_load = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b101:  fmt_load = {{(DATA_WIDTH-16){1'b0}}, h};
      3'b010:  fmt_load = word;
      default: fmt_load = '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    off_d   = off_q;
    f3_d    = f3_q;
    case (state_q)
      S_IDLE: begin
        if (o_GNT) begin
          if (illegal) begin
            state_d = S_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
            off_d   = i_ADDR[1:0];
            f3_d    = i_FUNCT3;
            err_d   = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (i_UROM_VALID) begin
          state_d = S_RESP;
          rdata_d = fmt_load(i_UROM_RDATA, off_q, f3_q);
          err_d   = 1'b0;
        end
      end
      S_RESP: begin
        if (i_RREADY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
    end
  end

endmodule

// File: tb/tb_uro_load_unit.sv
// Scoreboard bench for uro_load_unit: random loads against a spec-level reference model,
// plus directed latency, back-pressure, illegal-funct3 and reset-abandon scenarios.
module tb_uro_load_unit;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          gnt;
  logic [AW-1:0] addr = '0;
  logic [2:0]    f3 = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready = 1'b0;
  logic          err;
  logic          ce;
  logic [AW-1:0] uaddr;
  logic [DW-1:0] urdata = '0;
  logic          uvalid = 1'b0;

  uro_load_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .UROM_DEPTH(1024)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_REQ(req), .o_GNT(gnt), .i_ADDR(addr),
    .i_FUNCT3(f3), .o_RDATA(rdata), .o_RVALID(rvalid), .i_RREADY(rready),
    .o_ERR(err), .o_UROM_CE(ce), .o_UROM_ADDR(uaddr),
    .i_UROM_RDATA(urdata), .i_UROM_VALID(uvalid)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  int          n_chk = 0;
  int          n_fail = 0;
  int          ce_seen = 0;
  int          ce_expected = 0;
  int          rr_mode = 1;   // 0 random, 1 always ready, 2 never ready
  logic [32:0] exp_q [$];

  // ROM model answers one cycle after each enable; deliberately not reset.
  always @(posedge clk) begin
    uvalid <= ce;
    urdata <= ce ? mem[uaddr[3:0]] : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       rready = ($urandom_range(0, 3) != 0);
      1:       rready = 1'b1;
      default: rready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, expv, $time);
    end
  endtask

  // Reference: {err, data} derived directly from the load rules.
  function automatic logic [32:0] ref_load(input logic [31:0] a, input logic [2:0] fn);
    logic [31:0] w;
    int          off, b, h;
    bit          mis;
    logic [31:0] r;
    w   = mem[a[5:2]];
    off = int'(a[1:0]);
    mis = 1'b0;
`ifdef UROM_LOAD_MISALIGN_EN
    mis = ((fn == 3'd1 || fn == 3'd5) && (off % 2 != 0)) || (fn == 3'd2 && off != 0);
`endif
    if (fn == 3'd3 || fn == 3'd6 || fn == 3'd7 || mis) return {1'b1, 32'h0};
    b = int'((w >> (8 * off)) & 32'hFF);
    h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
    case (fn)
      3'd0:    r = (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd4:    r = 32'(b);
      3'd1:    r = (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd5:    r = 32'(h);
      default: r = w;
    endcase
    return {1'b0, r};
  endfunction

  function automatic bit is_legal(input logic [32:0] e);
    return !e[32];
  endfunction

  // push: 0 = nothing expected, 1 = reference model, 2 = explicit value
  task automatic issue(input logic [31:0] a, input logic [2:0] fn, input int push,
                       input logic [32:0] expv);
    int t;
    logic [32:0] e;
    e = ref_load(a, fn);
    @(posedge clk); #1;
    req = 1'b1; addr = a; f3 = fn;
    #1;
    t = 0;
    while (!gnt && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 50) chk("gnt_timeout", 32'(gnt), 32'd1);
    chk("ce_on_accept", 32'(ce), 32'(is_legal(e)));
    if (is_legal(e)) begin
      chk("urom_addr", uaddr, a >> 2);
      ce_expected++;
    end
    if (push == 1) exp_q.push_back(e);
    else if (push == 2) exp_q.push_back(expv);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops on handshake, checks hold stability and idle-side quiet outputs.
  logic        hold = 1'b0;
  logic [31:0] hold_d;
  logic        hold_e;
  always @(negedge clk) begin
    logic [32:0] e;
    if (ce) ce_seen++;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (!rvalid) chk("err_outside_resp", 32'(err), 32'd0);
      if (hold) begin
        chk("hold_valid", 32'(rvalid), 32'd1);
        chk("hold_data", rdata, hold_d);
        chk("hold_err", 32'(err), 32'(hold_e));
      end
      hold = 1'b0;
      if (rvalid) begin
        if (rready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rvalid", 32'(rvalid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rdata", rdata, e[31:0]);
            chk("err", 32'(err), 32'(e[32]));
          end
        end else begin
          hold   = 1'b1;
          hold_d = rdata;
          hold_e = err;
        end
      end
    end
  end

  initial begin
    int t;
    mem[0] = 32'h8001_7F80;
    mem[1] = 32'h1234_5678;
    for (int i = 2; i < 16; i++) mem[i] = $urandom;

    #1;
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_ce", 32'(ce), 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // LB at 0: WAIT cycle then response on the following cycle.
    rr_mode = 1;
    issue(32'h0, 3'd0, 2, {1'b0, 32'hFFFF_FF80});
    @(negedge clk); chk("lat_wait_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk); chk("lat_resp_rvalid", 32'(rvalid), 32'd1);
    drain();

    issue(32'h1, 3'd4, 2, {1'b0, 32'h0000_007F});
    issue(32'h2, 3'd5, 2, {1'b0, 32'h0000_8001});
    issue(32'h2, 3'd1, 2, {1'b0, 32'hFFFF_8001});
    drain();

    // Illegal funct3: straight to RESP with error.
    issue(32'h0, 3'd3, 2, {1'b1, 32'h0});
    @(negedge clk); chk("illegal_lat_rvalid", 32'(rvalid), 32'd1);
    drain();

`ifdef UROM_LOAD_MISALIGN_EN
    issue(32'h6, 3'd2, 2, {1'b1, 32'h0});
`else
    issue(32'h6, 3'd2, 2, {1'b0, 32'h1234_5678});
`endif
    drain();

    // Back-pressure: response held while ready is low; no grant while busy.
    rr_mode = 2;
    issue(32'h4, 3'd2, 2, {1'b0, 32'h1234_5678});
    t = 0;
    while (!rvalid && t < 20) begin @(negedge clk); t++; end
    chk("bp_rvalid_seen", 32'(rvalid), 32'd1);
    req = 1'b1; addr = 32'h8; f3 = 3'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_gnt_low", 32'(gnt), 32'd0);
      chk("bp_rdata", rdata, 32'h1234_5678);
      @(negedge clk);
    end
    req = 1'b0;
    rr_mode = 1;
    drain();

    // Reset while waiting on the ROM: transaction abandoned, late data ignored.
    issue(32'h0, 3'd2, 0, '0);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wait_rdata", rdata, 32'd0);
    chk("rst_wait_err", 32'(err), 32'd0);
    chk("rst_wait_ce", 32'(ce), 32'd0);
    chk("rst_wait_uaddr", uaddr, 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rvalid", 32'(rvalid), 32'd0);
    end
    issue(32'h0, 3'd2, 2, {1'b0, 32'h8001_7F80});
    drain();

    // Randomized traffic with random back-pressure.
    rr_mode = 0;
    for (int i = 0; i < 80; i++) begin
      issue($urandom_range(0, 63), 3'($urandom_range(0, 7)), 1, '0);
    end
    rr_mode = 1;
    drain();
    repeat (3) @(negedge clk);
    chk("ce_pulse_count", 32'(ce_seen), 32'(ce_expected));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
